// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial adder/subtractor controller. Drives one external
//               combinational 1-bit full-adder cell for WIDTH cycles, LSB
//               first, holding the ripple carry between cycles in a register.
//               Subtraction is done as a + ~b + 1.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               start, sub, cin   - request, operation select, add carry-in
//               a, b              - operands (sampled with an accepted start)
//               busy, done        - busy in RUN/DONE; one-cycle done pulse
//               sum, cout, ovf    - result, carry/no-borrow, signed overflow
//               fa_a, fa_b, fa_cin - drive to the full-adder cell
//               fa_sum, fa_cout   - same-cycle response from the cell
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res_sh;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;

    logic             w_run;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    assign w_run      = (r_state == c_run);
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    // Result bits arrive LSB first, so each new bit enters at the MSB and
    // after WIDTH shifts bit 0 has reached position 0.
    assign w_res_next = {fa_sum, r_res_sh[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_idle;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_a_sh   <= a;
                        r_b_sh   <= sub ? ~b : b;
                        r_carry  <= sub ? 1'b1 : cin;
                        r_res_sh <= '0;
                        r_cnt    <= '0;
                        r_state  <= c_run;
                    end
                end
                c_run: begin
                    r_res_sh <= w_res_next;
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_carry  <= fa_cout;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_sum   <= w_res_next;
                        r_cout  <= fa_cout;
                        // r_carry is the carry into the MSB on this edge.
                        r_ovf   <= r_carry ^ fa_cout;
                        r_state <= c_done;
                    end
                end
                c_done: begin
                    r_state <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign busy   = (r_state == c_run) || (r_state == c_done);
    assign done   = (r_state == c_done);
    assign sum    = r_sum;
    assign cout   = r_cout;
    assign ovf    = r_ovf;
    assign fa_a   = w_run & r_a_sh[0];
    assign fa_b   = w_run & r_b_sh[0];
    assign fa_cin = w_run & r_carry;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Self-checking bench for serial_add_ctrl with a behavioural
//               full-adder cell attached to the fa_* ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             fa_a;
    logic             fa_b;
    logic             fa_cin;
    logic             fa_sum;
    logic             fa_cout;

    int checks;
    int failures;

    serial_add_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .sub     (sub),
        .cin     (cin),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .ovf     (ovf),
        .fa_a    (fa_a),
        .fa_b    (fa_b),
        .fa_cin  (fa_cin),
        .fa_sum  (fa_sum),
        .fa_cout (fa_cout)
    );

    // Combinational full-adder cell.
    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents a request for one edge; returns at the negedge after it.
    task automatic launch(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tcin, input logic tsub);
        @(negedge clk);
        a = ta; b = tb; cin = tcin; sub = tsub; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) until done is seen at a negedge.
    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 2 * WIDTH + 4; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_busy_done got=%b exp=00", {busy, done});
        end
        checks++;
        if ({cout, ovf, sum} !== 10'h000) begin
            failures++;
            $display("FAIL reset_result got sum=%h cout=%b ovf=%b exp 00/0/0", sum, cout, ovf);
        end
        checks++;
        if ({fa_a, fa_b, fa_cin} !== 3'b000) begin
            failures++;
            $display("FAIL reset_fa got=%b exp=000", {fa_a, fa_b, fa_cin});
        end
        // Start held during reset must not be accepted.
        start = 1'b1; a = 8'hFF; b = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_priority busy=%b exp=0", busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [WIDTH-1:0] va [6];
        logic [WIDTH-1:0] vb [6];
        logic             vc [6];
        logic             vs [6];
        logic [WIDTH-1:0] es [6];
        logic             ec [6];
        logic             eo [6];
        bit seen;
        va = '{8'h5A, 8'hFF, 8'h7F, 8'h10, 8'h80, 8'h00};
        vb = '{8'h3C, 8'h01, 8'h00, 8'h20, 8'h01, 8'h00};
        vc = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0};
        vs = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};
        es = '{8'h96, 8'h00, 8'h80, 8'hF0, 8'h7F, 8'h00};
        ec = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
        eo = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
        for (int i = 0; i < 6; i++) begin
            launch(va[i], vb[i], vc[i], vs[i]);
            wait_done(seen);
            checks++;
            if (!seen || sum !== es[i] || cout !== ec[i] || ovf !== eo[i]) begin
                failures++;
                $display("FAIL directed_%0d seen=%0b got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
                         i, seen, sum, cout, ovf, es[i], ec[i], eo[i]);
            end
        end
    endtask

    task automatic test_timing;
        bit seen;
        launch(8'h13, 8'h34, 1'b0, 1'b0);
        // Operand changes after acceptance must not matter.
        a = 8'hFF; b = 8'hFF; cin = 1'b1;
        checks++;
        if ({busy, done, fa_a, fa_b, fa_cin} !== 5'b10100) begin
            failures++;
            $display("FAIL timing_first_bit got busy/done/fa=%b exp=10100",
                     {busy, done, fa_a, fa_b, fa_cin});
        end
        for (int k = 1; k <= WIDTH; k++) begin
            @(posedge clk);
            @(negedge clk);
            start = (k == 2);
            if (k == 2) begin
                a = 8'h01; b = 8'h01; sub = 1'b1;
            end
            checks++;
            if (k < WIDTH) begin
                if ({busy, done} !== 2'b10) begin
                    failures++;
                    $display("FAIL timing_run_e%0d got busy/done=%b exp=10", k, {busy, done});
                end
            end else begin
                if ({busy, done} !== 2'b11 || sum !== 8'h47 || cout !== 1'b0) begin
                    failures++;
                    $display("FAIL timing_done_e%0d got busy/done=%b sum=%h cout=%b exp 11 47 0",
                             k, {busy, done}, sum, cout);
                end
            end
        end
        // start during the done cycle is ignored.
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL timing_after_done got busy/done=%b exp=00", {busy, done});
        end
        launch(8'h01, 8'h01, 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b1 || sum !== 8'h47) begin
            failures++;
            $display("FAIL timing_hold got busy=%b sum=%h exp 1 47", busy, sum);
        end
        wait_done(seen);
        checks++;
        if (!seen || sum !== 8'h02) begin
            failures++;
            $display("FAIL timing_second got seen=%0b sum=%h exp 1 02", seen, sum);
        end
    endtask

    task automatic test_reset_mid;
        bit seen;
        bit bad;
        launch(8'hAA, 8'h55, 1'b0, 1'b0);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, cout, ovf} !== 4'b0000 || sum !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid got busy=%b done=%b sum=%h cout=%b ovf=%b exp all 0",
                     busy, done, sum, cout, ovf);
        end
        bad = 1'b0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL reset_mid_no_done got activity=1 exp=0");
        end
        launch(8'hAA, 8'h55, 1'b0, 1'b0);
        wait_done(seen);
        checks++;
        if (!seen || sum !== 8'hFF || cout !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_restart got seen=%0b sum=%h cout=%b ovf=%b exp 1 FF 0 0",
                     seen, sum, cout, ovf);
        end
    endtask

    task automatic test_sweep;
        bit seen;
        logic [WIDTH-1:0] ra, rb, bb, es;
        logic             rc, rs, c0, ec, eo;
        int               bad;
        bad = 0;
        for (int n = 0; n < 500; n++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            bb = rs ? ~rb : rb;
            c0 = rs ? 1'b1 : rc;
            {ec, es} = {1'b0, ra} + {1'b0, bb} + {{WIDTH{1'b0}}, c0};
            eo = (ra[WIDTH-1] == bb[WIDTH-1]) && (es[WIDTH-1] != ra[WIDTH-1]);
            launch(ra, rb, rc, rs);
            wait_done(seen);
            checks++;
            if (!seen || sum !== es || cout !== ec || ovf !== eo) begin
                failures++;
                bad++;
                if (bad <= 5)
                    $display("FAIL sweep_%0d a=%h b=%h cin=%b sub=%b seen=%0b got %h/%b/%b exp %h/%b/%b",
                             n, ra, rb, rc, rs, seen, sum, cout, ovf, es, ec, eo);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_timing();
        test_reset_mid();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
